// File: rtl/counter_pkg.sv
// Shared constants for the stopwatch display path: active-low glyphs,
// field limits and the digit count.
package counter_pkg;

  localparam int N_DIGITS = 6;

  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MS10_MAX = 7'd99;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [5:0] AN_OFF   = 6'b111111;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin2bcd_7.sv
// Combinational 7-bit binary to two-digit BCD converter with a range check
// against a caller-supplied limit.
module bin2bcd_7 (
  input  logic [6:0] value,
  input  logic [6:0] limit,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       valid
);

  logic [6:0] tens_full_s;
  logic [6:0] units_full_s;

  // Constant divisor keeps this a small shift/add network after synthesis
  always_comb begin
    tens_full_s  = value / 7'd10;
    units_full_s = value % 7'd10;
  end

  assign tens  = tens_full_s[3:0];
  assign units = units_full_s[3:0];
  assign valid = (value <= limit);

endmodule

// File: rtl/counter_display.sv
// Six-digit multiplexed seven-segment driver for MM.SS.CC; the time is
// snapshotted once per scan frame so a frame never mixes two readings.
module counter_display
  import counter_pkg::*;
#(
  parameter int scan_div = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blank,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] ms_10_i,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (scan_div > 2) ? $clog2(scan_div) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(scan_div - 1);
  localparam logic [2:0] DIG_LAST = 3'(N_DIGITS - 1);

  logic [CNT_W-1:0] div_cnt_r;
  logic [2:0]       dig_r;
  logic [5:0]       snap_min_r;
  logic [5:0]       snap_sec_r;
  logic [6:0]       snap_ms_r;
  logic [5:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             wrap_s;
  logic [3:0]       min_tens_s, min_units_s;
  logic [3:0]       sec_tens_s, sec_units_s;
  logic [3:0]       ms_tens_s, ms_units_s;
  logic             min_ok_s, sec_ok_s, ms_ok_s;
  logic [3:0]       bcd_s;
  logic             bcd_ok_s;
  logic [5:0]       an_next_s;
  logic [6:0]       seg_next_s;
  logic             dp_next_s;

  assign wrap_s = (div_cnt_r == CNT_LAST);

  bin2bcd_7 u_min (
    .value (1'b0 & 1'b0 ? 7'd0 : {1'b0, snap_min_r}),
    .limit (MIN_MAX),
    .tens  (min_tens_s),
    .units (min_units_s),
    .valid (min_ok_s)
  );

  bin2bcd_7 u_sec (
    .value ({1'b0, snap_sec_r}),
    .limit (SEC_MAX),
    .tens  (sec_tens_s),
    .units (sec_units_s),
    .valid (sec_ok_s)
  );

  bin2bcd_7 u_ms (
    .value (snap_ms_r),
    .limit (MS10_MAX),
    .tens  (ms_tens_s),
    .units (ms_units_s),
    .valid (ms_ok_s)
  );

  // Scan counter, digit index and frame snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r  <= '0;
      dig_r      <= 3'd0;
      snap_min_r <= 6'd0;
      snap_sec_r <= 6'd0;
      snap_ms_r  <= 7'd0;
    end else if (wrap_s) begin
      div_cnt_r <= '0;
      if (dig_r == DIG_LAST) begin
        dig_r      <= 3'd0;
        snap_min_r <= min_i;
        snap_sec_r <= sec_i;
        snap_ms_r  <= ms_10_i;
      end else begin
        dig_r <= dig_r + 3'd1;
      end
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1);
    end
  end

  // Select the BCD digit and its field's validity for the current index
  always_comb begin
    bcd_s    = 4'd0;
    bcd_ok_s = 1'b0;
    case (dig_r)
      3'd0: begin bcd_s = ms_units_s;  bcd_ok_s = ms_ok_s;  end
      3'd1: begin bcd_s = ms_tens_s;   bcd_ok_s = ms_ok_s;  end
      3'd2: begin bcd_s = sec_units_s; bcd_ok_s = sec_ok_s; end
      3'd3: begin bcd_s = sec_tens_s;  bcd_ok_s = sec_ok_s; end
      3'd4: begin bcd_s = min_units_s; bcd_ok_s = min_ok_s; end
      3'd5: begin bcd_s = min_tens_s;  bcd_ok_s = min_ok_s; end
      default: begin bcd_s = 4'd0; bcd_ok_s = 1'b0; end
    endcase
  end

  // Next-cycle pin values; blank only darkens anodes and the point
  always_comb begin
    if (bcd_ok_s) begin
      seg_next_s = bcd_glyph(bcd_s);
    end else begin
      seg_next_s = SEG_DASH;
    end
    if (blank) begin
      an_next_s = AN_OFF;
      dp_next_s = 1'b1;
    end else begin
      an_next_s = ~(6'b000001 << dig_r);
      dp_next_s = !((dig_r == 3'd2) || (dig_r == 3'd4));
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_counter_display.sv
// Randomized bench for counter_display against an elapsed-cycle model of the
// scan schedule, plus hand-computed spot checks.
module tb_counter_display;

  localparam int S     = 4;
  localparam int FRAME = 6 * S;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       blank = 1'b0;
  logic [5:0] min_i = 6'd0;
  logic [5:0] sec_i = 6'd0;
  logic [6:0] ms_10_i = 7'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_display #(.scan_div(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .blank   (blank),
    .min_i   (min_i),
    .sec_i   (sec_i),
    .ms_10_i (ms_10_i),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Digit d of the time mn:sc.ms, 0 = hundredths units ... 5 = minutes tens
  function automatic logic [6:0] digit_seg(input int d, input int mn, input int sc, input int ms);
    int v, lim;
    v   = (d < 2) ? ms : ((d < 4) ? sc : mn);
    lim = (d < 2) ? 99 : 59;
    if (v > lim) return 7'b0111111;
    return glyph((d % 2 == 1) ? (v / 10) : (v % 10));
  endfunction

  // Model: after e edges since release, digit (e/S)%6 is selected and the
  // frame snapshot is what the inputs held on the edge ending the last frame
  int         m_e;
  int         m_min, m_sec, m_ms;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_e     <= 0;
      m_min   <= 0;
      m_sec   <= 0;
      m_ms    <= 0;
      exp_an  <= 6'b111111;
      exp_seg <= 7'b1111111;
      exp_dp  <= 1'b1;
    end else begin
      m_e <= m_e + 1;
      if (m_e % FRAME == FRAME - 1) begin
        m_min <= int'(min_i);
        m_sec <= int'(sec_i);
        m_ms  <= int'(ms_10_i);
      end
      exp_an  <= blank ? 6'b111111 : ~(6'b000001 << ((m_e / S) % 6));
      exp_seg <= digit_seg((m_e / S) % 6, m_min, m_sec, m_ms);
      exp_dp  <= blank ? 1'b1 : !(((m_e / S) % 6 == 2) || ((m_e / S) % 6 == 4));
    end
  end

  always @(negedge clk) begin
    check("an", {26'd0, an}, {26'd0, exp_an});
    check("seg", {25'd0, seg}, {25'd0, exp_seg});
    check("dp", {31'd0, dp}, {31'd0, exp_dp});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] first_seg [6];
  logic [5:0] dp_pat;

  initial begin
    first_seg[0] = 7'b0000010; first_seg[1] = 7'b0010010;
    first_seg[2] = 7'b0011001; first_seg[3] = 7'b0110000;
    first_seg[4] = 7'b0100100; first_seg[5] = 7'b1111001;
    dp_pat = 6'b101011;

    min_i = 6'd12; sec_i = 6'd34; ms_10_i = 7'd56;
    step(3);
    check("reset_an", {26'd0, an}, 32'h3f);
    check("reset_seg", {25'd0, seg}, 32'h7f);
    rst = 1'b1;
    step(1);
    check("first_an", {26'd0, an}, 32'h3e);
    check("first_seg", {25'd0, seg}, 32'h40);
    step(24);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step(4);
      check("frame1_an", {26'd0, an}, {26'd0, ~(6'b000001 << j)});
      check("frame1_seg", {25'd0, seg}, {25'd0, first_seg[j]});
      check("frame1_dp", {31'd0, dp}, {31'd0, dp_pat[j]});
    end

    min_i = 6'd0; sec_i = 6'd5; ms_10_i = 7'd99;
    step(FRAME + 7);
    sec_i = 6'd6; ms_10_i = 7'd0;
    step(FRAME * 2);

    min_i = 6'd60; sec_i = 6'd59; ms_10_i = 7'd127;
    step(FRAME * 2 + 3);

    blank = 1'b1;
    step(10);
    blank = 1'b0;
    step(FRAME);

    repeat (300) begin
      min_i   = 6'($urandom_range(0, 63));
      sec_i   = 6'($urandom_range(0, 63));
      ms_10_i = 7'($urandom_range(0, 127));
      blank   = ($urandom_range(0, 7) == 0);
      step($urandom_range(1, 8));
    end
    blank = 1'b0;
    min_i = 6'd41; sec_i = 6'd17; ms_10_i = 7'd88;

    begin
      int n;
      n = 0;
      while (an !== 6'b110111 && n < 100) begin
        step(1);
        n++;
      end
      check("wait_dig3", {26'd0, an}, 32'h37);
    end
    #2;
    rst = 1'b0;
    #1;
    check("async_an", {26'd0, an}, 32'h3f);
    check("async_seg", {25'd0, seg}, 32'h7f);
    check("async_dp", {31'd0, dp}, 32'd1);
    step(2);
    rst = 1'b1;
    step(1);
    check("restart_an", {26'd0, an}, 32'h3e);
    check("restart_seg", {25'd0, seg}, 32'h40);
    step(FRAME * 2 + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
